memory_stage: RTL and testbench

Pipeline MEMORY stage sitting directly downstream of the execute stage and upstream of writeback. It turns load/store requests from execute into a request/grant/rvalid transaction on the data-memory port, generating byte enables, store lanes, and sign/zero-extended load data. It stalls the upstream stage while a memory transaction is outstanding and forwards the write-back payload in a registered stage.

---
 rtl/memory_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_memory_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: pipeline MEMORY stage between execute and writeback.
// Turns load/store requests into a req/gnt/rvalid transaction on the data
// memory port, builds byte enables and lane-replicated store data, extracts
// and sign/zero-extends load data, and stalls execute while a transaction is
// outstanding. The writeback payload is registered.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   valid_i .. memory_write_data_i  payload and memory request from execute
//   stall_o                   upstream must hold its inputs stable
//   dmem_req_o/we_o/addr_o/be_o/wdata_o  request side of the memory port
//   dmem_gnt_i/rvalid_i/rdata_i          response side of the memory port
//   valid_o, rf_data_o, rf_addr_o, rf_write_enable_o, pc_o, instruction_o,
//   misaligned_o              registered writeback payload
module memory_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instruction_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic [4:0]      rf_addr_i,
  input  logic            rf_write_enable_i,
  input  logic            memory_read_enable_i,
  input  logic [XLEN-1:0] memory_read_addr_i,
  input  logic            memory_write_enable_i,
  input  logic [XLEN-1:0] memory_write_addr_i,
  input  logic [XLEN-1:0] memory_write_data_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            valid_o,
  output logic [XLEN-1:0] rf_data_o,
  output logic [4:0]      rf_addr_o,
  output logic            rf_write_enable_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instruction_o,
  output logic            misaligned_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_RVALID = 1'b1} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t          state_r, state_nxt_s;
  logic [1:0]      off_r;
  logic [2:0]      f3_r;

  logic [2:0]      funct3_s;
  logic            mem_op_s, is_load_s, misaligned_s;
  logic [XLEN-1:0] addr_s;
  logic [1:0]      size_s;
  logic            req_s, stall_s, retire_s, retire_load_s, latch_s;
  logic            req_en_s;
  logic [XLEN-1:0] wb_data_s;
  logic            wb_we_s;

  // Pick the lane of a returned word and extend it according to funct3.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                   input logic [1:0] off,
                                                   input logic [2:0] f3);
    logic [XLEN-1:0] lane;
    lane = rdata >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   load_extract = f3[2] ? {{(XLEN-8){1'b0}}, lane[7:0]}
                                    : {{(XLEN-8){lane[7]}}, lane[7:0]};
      2'b01:   load_extract = f3[2] ? {{(XLEN-16){1'b0}}, lane[15:0]}
                                    : {{(XLEN-16){lane[15]}}, lane[15:0]};
      default: load_extract = rdata;
    endcase
  endfunction

  assign funct3_s  = instruction_i[14:12];
  assign mem_op_s  = valid_i & (memory_read_enable_i | memory_write_enable_i);
  assign is_load_s = memory_read_enable_i;  // read wins when both are set
  assign addr_s    = is_load_s ? memory_read_addr_i : memory_write_addr_i;

  // Access size decode; unknown funct3 values fall back to a full word.
  always_comb begin
    size_s = SZ_WORD;
    if (is_load_s) begin
      case (funct3_s[1:0])
        2'b00:   size_s = SZ_BYTE;
        2'b01:   size_s = SZ_HALF;
        default: size_s = SZ_WORD;
      endcase
    end else begin
      case (funct3_s)
        3'b000:  size_s = SZ_BYTE;
        3'b001:  size_s = SZ_HALF;
        default: size_s = SZ_WORD;
      endcase
    end
  end

  assign misaligned_s = mem_op_s &
                        (((size_s == SZ_HALF) & addr_s[0]) |
                         ((size_s == SZ_WORD) & (addr_s[1:0] != 2'b00)));

  // Next-state, request, stall and retire decisions.
  always_comb begin
    state_nxt_s   = state_r;
    req_s         = 1'b0;
    stall_s       = 1'b0;
    retire_s      = 1'b0;
    retire_load_s = 1'b0;
    latch_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_op_s && !misaligned_s) begin
          req_s = 1'b1;
          if (dmem_gnt_i) begin
            if (is_load_s) begin
              // Load accepted: still waiting for data, so keep execute held.
              latch_s     = 1'b1;
              stall_s     = 1'b1;
              state_nxt_s = WAIT_RVALID;
            end else begin
              retire_s = 1'b1;
            end
          end else begin
            stall_s = 1'b1;
          end
        end else if (valid_i) begin
          // Plain ALU op or misaligned access: single-cycle pass.
          retire_s = 1'b1;
        end else begin
          retire_s = 1'b0;
        end
      end
      WAIT_RVALID: begin
        if (dmem_rvalid_i) begin
          retire_s      = 1'b1;
          retire_load_s = 1'b1;
          state_nxt_s   = IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  assign req_en_s = req_s & ~rst_i;
  assign stall_o  = stall_s & ~rst_i;

  // Memory request fields; held at zero whenever no request is driven.
  always_comb begin
    dmem_req_o   = req_en_s;
    dmem_we_o    = req_en_s & ~is_load_s;
    dmem_addr_o  = {XLEN{1'b0}};
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = {XLEN{1'b0}};
    if (req_en_s) begin
      dmem_addr_o = {addr_s[XLEN-1:2], 2'b00};
      case (size_s)
        SZ_BYTE: begin
          dmem_be_o    = 4'b0001 << addr_s[1:0];
          dmem_wdata_o = {4{memory_write_data_i[7:0]}};
        end
        SZ_HALF: begin
          dmem_be_o    = addr_s[1] ? 4'b1100 : 4'b0011;
          dmem_wdata_o = {2{memory_write_data_i[15:0]}};
        end
        default: begin
          dmem_be_o    = 4'b1111;
          dmem_wdata_o = memory_write_data_i;
        end
      endcase
    end else begin
      dmem_be_o = 4'b0000;
    end
  end

  assign wb_data_s = retire_load_s ? load_extract(dmem_rdata_i, off_r, f3_r) : alu_data_i;
  // Stores and misaligned accesses never write the register file.
  assign wb_we_s   = retire_load_s ? rf_write_enable_i
                                   : (mem_op_s ? 1'b0 : rf_write_enable_i);

  // State, load context and writeback payload registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r           <= IDLE;
      off_r             <= 2'b00;
      f3_r              <= 3'b000;
      valid_o           <= 1'b0;
      rf_data_o         <= {XLEN{1'b0}};
      rf_addr_o         <= 5'd0;
      rf_write_enable_o <= 1'b0;
      pc_o              <= {XLEN{1'b0}};
      instruction_o     <= {XLEN{1'b0}};
      misaligned_o      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (latch_s) begin
        off_r <= addr_s[1:0];
        f3_r  <= funct3_s;
      end
      if (retire_s) begin
        valid_o           <= 1'b1;
        rf_data_o         <= wb_data_s;
        rf_addr_o         <= rf_addr_i;
        rf_write_enable_o <= wb_we_s;
        pc_o              <= pc_i;
        instruction_o     <= instruction_i;
        misaligned_o      <= misaligned_s & ~retire_load_s;
      end else begin
        valid_o           <= 1'b0;
        rf_write_enable_o <= 1'b0;
        misaligned_o      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] pc_i, instruction_i, alu_data_i;
  logic [4:0]  rf_addr_i;
  logic        rf_write_enable_i;
  logic        memory_read_enable_i, memory_write_enable_i;
  logic [31:0] memory_read_addr_i, memory_write_addr_i, memory_write_data_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o, rf_write_enable_o, misaligned_o;
  logic [31:0] rf_data_o, pc_o, instruction_o;
  logic [4:0]  rf_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  memory_stage #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
    .instruction_i(instruction_i), .alu_data_i(alu_data_i),
    .rf_addr_i(rf_addr_i), .rf_write_enable_i(rf_write_enable_i),
    .memory_read_enable_i(memory_read_enable_i), .memory_read_addr_i(memory_read_addr_i),
    .memory_write_enable_i(memory_write_enable_i), .memory_write_addr_i(memory_write_addr_i),
    .memory_write_data_i(memory_write_data_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_o(valid_o), .rf_data_o(rf_data_o), .rf_addr_o(rf_addr_o),
    .rf_write_enable_o(rf_write_enable_o), .pc_o(pc_o),
    .instruction_o(instruction_o), .misaligned_o(misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: size in bytes of an access (unknown funct3 -> word).
  function automatic int acc_bytes(input logic is_load, input logic [2:0] f3);
    int n;
    n = 4;
    if (is_load) begin
      if (f3 == 3'd0 || f3 == 3'd4) n = 1;
      else if (f3 == 3'd1 || f3 == 3'd5) n = 2;
    end else begin
      if (f3 == 3'd0) n = 1;
      else if (f3 == 3'd1) n = 2;
    end
    return n;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off, input logic [2:0] f3);
    logic [31:0] v;
    int n;
    n = acc_bytes(1'b1, f3);
    v = rdata >> (8 * off);
    if (n == 1) begin
      v = v % 32'd256;
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (n == 2) begin
      v = v % 32'd65536;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic clear_inputs();
    valid_i = 1'b0; memory_read_enable_i = 1'b0; memory_write_enable_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  // One idle cycle, optionally with a stray rvalid that must be ignored.
  task automatic idle_cycle(input logic rv);
    clear_inputs();
    dmem_rvalid_i = rv;
    dmem_rdata_i  = $urandom;
    #1;
    check_eq("idle_stall", {31'd0, stall_o}, 32'd0);
    check_eq("idle_req", {31'd0, dmem_req_o}, 32'd0);
    @(negedge clk_i);
    check_eq("idle_valid", {31'd0, valid_o}, 32'd0);
    dmem_rvalid_i = 1'b0;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 load+store (load wins). Called at a negedge;
  // returns at the negedge after retirement with the payload checked.
  task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] alu,
                       input int gd, input int rd, input logic [31:0] rdata);
    logic        is_mem, is_load, mis, rfwe, exp_we;
    logic [31:0] pc, instr, exp_be, exp_wd;
    logic [4:0]  rfa;
    int          n, off;
    is_mem  = (kind != 0);
    is_load = (kind == 1 || kind == 3);
    n       = acc_bytes(is_load, f3);
    off     = int'(addr % 32'd4);
    mis     = is_mem && ((n == 2 && (off % 2) != 0) || (n == 4 && off != 0));
    pc      = $urandom;
    instr   = ($urandom & 32'hFFFF8FFF) | ({29'd0, f3} << 12);
    rfa     = 5'($urandom_range(0, 31));
    rfwe    = 1'($urandom_range(0, 1));
    exp_we  = (!is_mem || (is_load && !mis)) ? rfwe : 1'b0;
    if (n == 1) begin
      exp_be = 32'd1 << off;
      exp_wd = (data % 32'd256) * 32'h01010101;
    end else if (n == 2) begin
      exp_be = (off >= 2) ? 32'hC : 32'h3;
      exp_wd = (data % 32'd65536) * 32'h00010001;
    end else begin
      exp_be = 32'hF;
      exp_wd = data;
    end
    valid_i = 1'b1; pc_i = pc; instruction_i = instr; alu_data_i = alu;
    rf_addr_i = rfa; rf_write_enable_i = rfwe;
    memory_read_enable_i  = is_load;
    memory_write_enable_i = (kind == 2 || kind == 3);
    memory_read_addr_i    = is_load ? addr : $urandom;
    memory_write_addr_i   = is_load ? $urandom : addr;
    memory_write_data_i   = data;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    if (!is_mem || mis) begin
      #1;
      check_eq("pass_stall", {31'd0, stall_o}, 32'd0);
      check_eq("pass_req", {31'd0, dmem_req_o}, 32'd0);
      @(negedge clk_i);
    end else begin
      for (int k = 0; k <= gd; k++) begin
        dmem_gnt_i = (k == gd);
        #1;
        check_eq("req", {31'd0, dmem_req_o}, 32'd1);
        check_eq("we", {31'd0, dmem_we_o}, is_load ? 32'd0 : 32'd1);
        check_eq("addr", dmem_addr_o, addr - (addr % 32'd4));
        check_eq("stall_req", {31'd0, stall_o}, (is_load || k < gd) ? 32'd1 : 32'd0);
        if (!is_load) begin
          check_eq("be", {28'd0, dmem_be_o}, exp_be);
          check_eq("wdata", dmem_wdata_o, exp_wd);
        end
        if (k > 0) check_eq("valid_wait", {31'd0, valid_o}, 32'd0);
        @(negedge clk_i);
      end
      dmem_gnt_i = 1'b0;
      if (is_load) begin
        for (int j = 1; j <= rd; j++) begin
          dmem_rvalid_i = (j == rd);
          dmem_rdata_i  = (j == rd) ? rdata : $urandom;
          #1;
          check_eq("req_wait", {31'd0, dmem_req_o}, 32'd0);
          check_eq("stall_wait", {31'd0, stall_o}, (j < rd) ? 32'd1 : 32'd0);
          check_eq("valid_rwait", {31'd0, valid_o}, 32'd0);
          @(negedge clk_i);
        end
      end
    end
    check_eq("valid_o", {31'd0, valid_o}, 32'd1);
    check_eq("pc_o", pc_o, pc);
    check_eq("instr_o", instruction_o, instr);
    check_eq("rf_addr_o", {27'd0, rf_addr_o}, {27'd0, rfa});
    check_eq("rf_we_o", {31'd0, rf_write_enable_o}, {31'd0, exp_we});
    check_eq("misaligned_o", {31'd0, misaligned_o}, {31'd0, mis});
    if (!is_mem) check_eq("alu_data", rf_data_o, alu);
    else if (is_load && !mis) check_eq("load_data", rf_data_o, model_load(rdata, off, f3));
    clear_inputs();
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    pc_i = 32'd0; instruction_i = 32'd0; alu_data_i = 32'd0; rf_addr_i = 5'd0;
    rf_write_enable_i = 1'b0; memory_read_addr_i = 32'd0; memory_write_addr_i = 32'd0;
    memory_write_data_i = 32'd0; dmem_rdata_i = 32'd0;
    @(negedge clk_i);
    // A valid aligned load presented during reset must not raise a request.
    valid_i = 1'b1; memory_read_enable_i = 1'b1; memory_read_addr_i = 32'h40;
    instruction_i = 32'h00002000;
    #1;
    check_eq("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check_eq("rst_stall", {31'd0, stall_o}, 32'd0);
    check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
    check_eq("rst_we", {31'd0, rf_write_enable_o}, 32'd0);
    check_eq("rst_rf_data", rf_data_o, 32'd0);
    check_eq("rst_pc", pc_o, 32'd0);
    check_eq("rst_mis", {31'd0, misaligned_o}, 32'd0);
    @(negedge clk_i);
    clear_inputs();
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed cases.
    do_op(0, 3'b000, 32'h0, 32'h0, 32'h1234, 0, 0, 32'h0);            // ADD
    do_op(2, 3'b000, 32'h103, 32'hAB, 32'h0, 2, 0, 32'h0);            // SB
    do_op(1, 3'b000, 32'h102, 32'h0, 32'h0, 0, 3, 32'h00800000);      // LB
    do_op(1, 3'b100, 32'h102, 32'h0, 32'h0, 0, 3, 32'h00800000);      // LBU
    do_op(1, 3'b010, 32'h206, 32'h0, 32'h0, 0, 1, 32'h0);             // LW misaligned
    do_op(1, 3'b001, 32'h302, 32'h0, 32'h0, 1, 1, 32'h8001_1234);     // LH upper half
    do_op(2, 3'b001, 32'h302, 32'hBEEF, 32'h0, 0, 0, 32'h0);          // SH upper half

    // Reset while waiting for rvalid, then a late rvalid must be discarded.
    valid_i = 1'b1; memory_read_enable_i = 1'b1; memory_write_enable_i = 1'b0;
    memory_read_addr_i = 32'h300; instruction_i = 32'h00002003;
    dmem_gnt_i = 1'b1;
    #1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    #1;
    check_eq("midload_stall", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check_eq("midrst_stall", {31'd0, stall_o}, 32'd0);
    check_eq("midrst_req", {31'd0, dmem_req_o}, 32'd0);
    check_eq("midrst_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk_i);
    clear_inputs();
    rst_i = 1'b0;
    @(negedge clk_i);
    idle_cycle(1'b1);

    // Randomized traffic, back-to-back with occasional idle cycles.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_cycle(1'($urandom_range(0, 1)));
      end else begin
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
        do_op(int'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), a, $urandom,
              $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
